// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE/ACCESS/DONE FSM in front of a 2^ADDR_W x 16 array.
// Optional macro DMEM_POSTED_WR_EN adds a one-entry posted-write buffer.
module dmem_responder #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dm_rd_en,
  input  logic        dm_wr_en,
  input  logic [15:0] addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        stall,
  output logic        busy
);

  localparam int         DEPTH        = 1 << ADDR_W;
  localparam logic [3:0] ACC_CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [3:0] PW_CNT_INIT  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic              r_is_wr;
  logic [15:0]       r_rd_data;
  logic [15:0]       r_mem [DEPTH];

  logic              w_req, w_accept, w_stall;
  logic              w_op_en, w_op_wr;
  logic [ADDR_W-1:0] w_op_addr;
  logic [15:0]       w_op_wdata;
  logic              w_post, w_pw_busy, w_pw_commit;
  logic [ADDR_W-1:0] w_pw_addr;
  logic [15:0]       w_pw_data;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [15:0]       w_mem_wdata;
  logic              w_unused;

  assign w_req    = dm_rd_en | dm_wr_en;
  // Upper address bits are dropped so the array wraps.
  assign w_unused = ^addr[15:ADDR_W];

`ifdef DMEM_POSTED_WR_EN
  logic              r_pw_valid;
  logic [3:0]        r_pw_cnt;
  logic [ADDR_W-1:0] r_pw_addr;
  logic [15:0]       r_pw_data;

  assign w_post      = (r_state == IDLE) && dm_wr_en && !r_pw_valid;
  assign w_pw_busy   = r_pw_valid;
  assign w_pw_commit = r_pw_valid && (r_pw_cnt == 4'd0);
  assign w_pw_addr   = r_pw_addr;
  assign w_pw_data   = r_pw_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pw_valid <= 1'b0;
      r_pw_cnt   <= 4'd0;
      r_pw_addr  <= '0;
      r_pw_data  <= 16'h0000;
    end else if (w_post) begin
      r_pw_valid <= 1'b1;
      r_pw_cnt   <= PW_CNT_INIT;
      r_pw_addr  <= addr[ADDR_W-1:0];
      r_pw_data  <= wr_data;
    end else if (r_pw_valid) begin
      if (r_pw_cnt == 4'd0) r_pw_valid <= 1'b0;
      else                  r_pw_cnt   <= r_pw_cnt - 4'd1;
    end
  end
`else
  assign w_post      = 1'b0;
  assign w_pw_busy   = 1'b0;
  assign w_pw_commit = 1'b0;
  assign w_pw_addr   = '0;
  assign w_pw_data   = 16'h0000;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_stall     = 1'b0;
    w_op_en     = 1'b0;
    w_op_wr     = r_is_wr;
    w_op_addr   = r_addr;
    w_op_wdata  = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (w_post) begin
          w_stall = 1'b0;
        end else if (w_req && w_pw_busy) begin
          w_stall = 1'b1;
        end else if (w_req) begin
          w_stall  = 1'b1;
          w_accept = 1'b1;
          if (LATENCY > 1) begin
            w_state_nxt = ACCESS;
            w_cnt_nxt   = ACC_CNT_INIT;
          end else begin
            // Single-cycle latency: the array is touched on the accepting edge.
            w_state_nxt = DONE;
            w_cnt_nxt   = 4'd0;
            w_op_en     = 1'b1;
            w_op_wr     = dm_wr_en;
            w_op_addr   = addr[ADDR_W-1:0];
            w_op_wdata  = wr_data;
          end
        end
      end
      ACCESS: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_op_en     = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_wdata   <= 16'h0000;
      r_is_wr   <= 1'b0;
      r_rd_data <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr  <= addr[ADDR_W-1:0];
        r_wdata <= wr_data;
        r_is_wr <= dm_wr_en;
      end
      if (w_op_en && !w_op_wr) r_rd_data <= r_mem[w_op_addr];
    end
  end

  assign w_mem_we    = rst_n && ((w_op_en && w_op_wr) || w_pw_commit);
  assign w_mem_addr  = w_pw_commit ? w_pw_addr : w_op_addr;
  assign w_mem_wdata = w_pw_commit ? w_pw_data : w_op_wdata;

  // NOTE: the array has no reset; clearing it would turn the RAM into a flop bank.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
  end

  assign stall    = w_stall & rst_n;
  assign rd_data  = r_rd_data;
  assign rd_valid = (r_state == DONE) && !r_is_wr;
  assign busy     = (r_state != IDLE) || w_pw_busy || stall;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: two instances (LATENCY 4 and 1), directed cases
// plus randomized traffic against an associative-array memory model.
module tb_dmem_responder;

  localparam int ADDR_W = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en   [2];
  logic        wr_en   [2];
  logic [15:0] addr_i  [2];
  logic [15:0] wdata_i [2];
  logic [15:0] rdata_o [2];
  logic        rvalid_o[2];
  logic        stall_o [2];
  logic        busy_o  [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lat [2]  = '{4, 1};
  bit          posted;
  logic [15:0] model_mem [int];
  logic [15:0] exp_rd [2];
  logic [15:0] wq [$];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(4), .ADDR_W(ADDR_W)) u_dut_l4 (
    .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[0]), .dm_wr_en(wr_en[0]),
    .addr(addr_i[0]), .wr_data(wdata_i[0]), .rd_data(rdata_o[0]),
    .rd_valid(rvalid_o[0]), .stall(stall_o[0]), .busy(busy_o[0])
  );

  dmem_responder #(.LATENCY(1), .ADDR_W(ADDR_W)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .dm_rd_en(rd_en[1]), .dm_wr_en(wr_en[1]),
    .addr(addr_i[1]), .wr_data(wdata_i[1]), .rd_data(rdata_o[1]),
    .rd_valid(rvalid_o[1]), .stall(stall_o[1]), .busy(busy_o[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int mkey(input int d, input logic [15:0] a);
    return d * 65536 + int'(a) % (1 << ADDR_W);
  endfunction

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (busy_o[d] && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Counts stall cycles from the current sample point; rd_valid must stay low meanwhile.
  task automatic count_stalls(input int d, input bit need_busy, output int n);
    n = 0;
    while (stall_o[d] && n < 50) begin
      check("rvalid_in_stall", rvalid_o[d], 1'b0);
      if (need_busy) check("busy_in_stall", busy_o[d], 1'b1);
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic finish_done(input int d, input bit is_wr, input logic [15:0] a);
    int key = mkey(d, a);
    if (is_wr) begin
      check("wr_rvalid", rvalid_o[d], 1'b0);
      check("rd_hold", rdata_o[d], exp_rd[d]);
    end else begin
      check("rd_rvalid", rvalid_o[d], 1'b1);
      if (model_mem.exists(key)) begin
        exp_rd[d] = model_mem[key];
        check($sformatf("rdata d%0d a%0h", d, a), rdata_o[d], exp_rd[d]);
      end
    end
    // Request stays asserted through DONE; it must not start a second access.
    @(negedge clk);
    rd_en[d] = 1'b0;
    wr_en[d] = 1'b0;
    #1;
    check("post_done_rvalid", rvalid_o[d], 1'b0);
    check("post_done_stall", stall_o[d], 1'b0);
  endtask

  task automatic access(input int d, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] wd);
    int n;
    int exp_stall = (posted && wr) ? 0 : lat[d];
    wait_idle(d);
    rd_en[d]   = rd;
    wr_en[d]   = wr;
    addr_i[d]  = a;
    wdata_i[d] = wd;
    #1;
    count_stalls(d, 1'b1, n);
    check($sformatf("stall_cycles d%0d", d), n, exp_stall);
    if (wr) model_mem[mkey(d, a)] = wd;
    finish_done(d, wr, a);
  endtask

  // Write followed by a read of the same word on the very next cycle the pipe allows.
  task automatic wr_then_rd(input int d, input logic [15:0] a, input logic [15:0] wd);
    int n;
    wait_idle(d);
    rd_en[d] = 1'b0; wr_en[d] = 1'b1; addr_i[d] = a; wdata_i[d] = wd;
    #1;
    count_stalls(d, 1'b1, n);
    check("raw_wr_stalls", n, posted ? 0 : lat[d]);
    model_mem[mkey(d, a)] = wd;
    check("raw_wr_rvalid", rvalid_o[d], 1'b0);
    @(negedge clk);
    rd_en[d] = 1'b1; wr_en[d] = 1'b0;
    #1;
    count_stalls(d, 1'b1, n);
    check("raw_rd_stalls", n, posted ? 2 * lat[d] : lat[d]);
    finish_done(d, 1'b0, a);
  endtask

  task automatic check_reset_outputs(input int d);
    check($sformatf("rst_rdata d%0d", d), rdata_o[d], 16'h0000);
    check($sformatf("rst_rvalid d%0d", d), rvalid_o[d], 1'b0);
    check($sformatf("rst_stall d%0d", d), stall_o[d], 1'b0);
    check($sformatf("rst_busy d%0d", d), busy_o[d], 1'b0);
  endtask

  task automatic reset_mid_write(input int d, input logic [15:0] a, input logic [15:0] wd);
    wait_idle(d);
    rd_en[d] = 1'b0; wr_en[d] = 1'b1; addr_i[d] = a; wdata_i[d] = wd;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    rd_en[d] = 1'b0; wr_en[d] = 1'b0;
    #1;
    check_reset_outputs(d);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd[0] = 16'h0000;
    exp_rd[1] = 16'h0000;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, base;
    int op;
`ifdef DMEM_POSTED_WR_EN
    posted = 1'b1;
`else
    posted = 1'b0;
`endif
    for (int d = 0; d < 2; d++) begin
      rd_en[d] = 1'b0; wr_en[d] = 1'b0; addr_i[d] = 16'h0; wdata_i[d] = 16'h0;
      exp_rd[d] = 16'h0000;
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Read-after-write on LATENCY=4, and back-to-back write/read.
    access(0, 1'b0, 1'b1, 16'h0003, 16'h1234);
    access(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    wr_then_rd(0, 16'h0020, 16'h00FF);

    // LATENCY=1 instance.
    access(1, 1'b0, 1'b1, 16'h0010, 16'hA5A5);
    access(1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    wr_then_rd(1, 16'h0011, 16'h3C3C);

    // Address wrap and both-enables conflict.
    access(0, 1'b0, 1'b1, 16'h0402, 16'h7777);
    access(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    access(0, 1'b1, 1'b1, 16'h0004, 16'h1111);
    access(0, 1'b1, 1'b0, 16'h0004, 16'h0000);

    // Reset in the middle of a write aborts it.
    access(0, 1'b0, 1'b1, 16'h0005, 16'h5A5A);
    reset_mid_write(0, 16'h0005, 16'hBEEF);
    access(0, 1'b1, 1'b0, 16'h0005, 16'h0000);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      wq.delete();
      for (int i = 0; i < 40; i++) begin
        op = int'($urandom_range(0, 3));
        if (op <= 1 && wq.size() > 0) begin
          base = wq[$urandom_range(0, wq.size() - 1)];
          a = {6'($urandom), base[9:0]};
          access(d, 1'b1, 1'b0, a, 16'($urandom));
        end else begin
          a = 16'($urandom);
          wq.push_back(a);
          access(d, 1'b1 & (op == 3), 1'b1, a, 16'($urandom));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, giving access latency in cycles; legal range is 1..15.
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the word-address width of the internal data array (2^ADDR_W x 16 bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port dm_rd_en, input, 1 bit: read request from the MEM stage.
REQ-006 The block SHALL have port dm_wr_en, input, 1 bit: write request from the MEM stage.
REQ-007 The block SHALL have port addr, input, 16 bits: word address (the ALU result of the MEM-stage instruction).
REQ-008 The block SHALL have port wr_data, input, 16 bits: store data.
REQ-009 The block SHALL have port rd_data, output, 16 bits: read result.
REQ-010 The block SHALL have port rd_valid, output, 1 bit: one-cycle strobe marking rd_data as valid for the current MEM instruction.
REQ-011 The block SHALL have port stall, output, 1 bit: freeze request to all pipe registers upstream of and including EX/MEM.
REQ-012 The block SHALL have port busy, output, 1 bit: an access is in flight (FSM not IDLE, or the posted-write buffer is occupied).

Function
REQ-013 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-014 In IDLE, when dm_rd_en or dm_wr_en is high, the block SHALL capture addr[ADDR_W-1:0], wr_data and the operation, and drive stall=1 combinationally in that same cycle.
REQ-015 From IDLE with a request, the FSM SHALL go to ACCESS with counter=LATENCY-2 when LATENCY>1, or directly to DONE when LATENCY=1.
REQ-016 In ACCESS, stall SHALL be 1 and the counter SHALL decrement each cycle; at counter=0 the FSM SHALL perform the array operation and move to DONE.
REQ-017 A request accepted in cycle T SHALL therefore produce exactly LATENCY stall cycles (T..T+LATENCY-1), with DONE at T+LATENCY.
REQ-018 In DONE, stall SHALL be 0, rd_valid SHALL be 1 for reads only, and the FSM SHALL return to IDLE unconditionally.
REQ-019 Requests presented during DONE SHALL be ignored, because they belong to the instruction that just completed.
REQ-020 While stall=1, the requester SHALL hold dm_rd_en, dm_wr_en, addr and wr_data stable; the block SHALL use only the captured copies.
REQ-021 rd_data SHALL hold its value until the next read completes.
REQ-022 When dm_rd_en and dm_wr_en are both high, the access SHALL be treated as a write, and rd_valid SHALL stay 0.
REQ-023 Address bits [15:ADDR_W] SHALL be ignored, so addresses wrap modulo 2^ADDR_W.

Reset
REQ-024 When rst_n is low, the block SHALL asynchronously force FSM=IDLE, counter=0, rd_data=0x0000, rd_valid=0, stall=0 and busy=0, and SHALL clear the posted-write buffer.
REQ-025 A reset during ACCESS SHALL abort the access; an aborted write SHALL NOT modify the array.
REQ-026 Array contents SHALL NOT be reset.

Configuration
REQ-027 With macro DMEM_POSTED_WR_EN defined, a write accepted in IDLE SHALL be placed in a one-entry buffer with stall=0 in that cycle, and SHALL commit to the array LATENCY cycles later; busy SHALL be 1 during that time.
REQ-028 With DMEM_POSTED_WR_EN defined, any request arriving while the buffer is occupied SHALL stall until the buffer drains and SHALL then be handled per REQ-014; a read after a write therefore returns the new data.
REQ-029 Without DMEM_POSTED_WR_EN, writes SHALL follow REQ-014..REQ-018 exactly like reads, with rd_valid=0.

Verification
REQ-030 Reset check: assert rst_n=0 mid-ACCESS of a write of 0xBEEF to address 0x005 -> all outputs go to their reset values immediately, and a later read of 0x005 does not return 0xBEEF.
REQ-031 Read-after-write, LATENCY=4, macro off: write 0x1234 to 0x003, then read 0x003 -> each access gives 4 stall cycles, then rd_valid=1 with rd_data=0x1234 in the read's DONE cycle.
REQ-032 LATENCY=1: read of 0x010 preloaded with 0xA5A5 -> stall=1 for exactly 1 cycle, then DONE with rd_valid=1 and rd_data=0xA5A5.
REQ-033 Wrap and conflict: with ADDR_W=10, write 0x7777 to 0x0402, then read 0x0002 -> rd_data=0x7777; with both enables high, writing 0x1111 -> write occurs and rd_valid stays 0.
REQ-034 Posted write, macro on, LATENCY=4: write 0x00FF to 0x020 immediately followed by a read of 0x020 -> 0 stall cycles on the write; the read stalls until the buffer drains, then returns rd_data=0x00FF; busy=1 throughout.
REQ-035 DONE-cycle hold: keep a read request asserted through DONE -> exactly one rd_valid pulse, and FSM goes back to IDLE with no second access.
